// File: rtl/audio_pkg.sv
// Shared audio definitions: default widths, echo FSM state type and a
// saturating adder used by the echo stage when ECHO_SATURATE_EN is defined.
package audio_pkg;

    localparam int D_WIDTH         = 24;
    localparam int ECHO_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        IDLE    = 3'd1,
        CAPTURE = 3'd2,
        READ    = 3'd3,
        MIX     = 3'd4,
        WRITE   = 3'd5
    } echo_state_t;

    // Signed add clamped to the range of a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end else if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port synchronous sample RAM, one-cycle read latency, no reset so it
// maps onto block RAM.
module sample_ram #(
    parameter int WIDTH      = 48,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/echo_effect.sv
// Stereo feedback echo: y = x + (y[n-depth] >>> decay_shift), dry when disabled.
// ECHO_SATURATE_EN defined clamps the mix sum; otherwise it wraps.
//   state   | meaning
//   CLEAR   | zero the delay RAM after reset; frame edges pass dry
//   IDLE    | wait for falling edge of i_ws
//   CAPTURE | latch input samples
//   READ    | address delay RAM at wr_ptr
//   MIX     | combine input with attenuated delayed output
//   WRITE   | store mix, update outputs, advance wr_ptr
module echo_effect
    import audio_pkg::*;
#(
    parameter int d_width     = D_WIDTH,
    parameter int addr_width  = ECHO_ADDR_WIDTH,
    parameter int decay_shift = 1
) (
    input  logic               mclk,
    input  logic               reset_n,
    input  logic               i_ws,
    input  logic               i_enable,
    input  logic [d_width-1:0] i_l_data,
    input  logic [d_width-1:0] i_r_data,
    output logic [d_width-1:0] o_l_data,
    output logic [d_width-1:0] o_r_data,
    output logic               o_sample_tick
);

    localparam logic [addr_width-1:0] PTR_LAST = '1;

    echo_state_t                state_q, state_d;
    logic                       ws_d_q;
    logic                       dry_pend_q;
    logic [addr_width-1:0]      wr_ptr_q, wr_ptr_d;
    logic signed [d_width-1:0]  x_l_q, x_r_q;
    logic signed [d_width-1:0]  y_l_q, y_r_q, y_l_d, y_r_d;
    logic signed [d_width-1:0]  d_l, d_r;
    logic                       frame_edge;
    logic                       ram_we;
    logic [2*d_width-1:0]       ram_wdata, ram_rdata;

    assign frame_edge = ws_d_q & ~i_ws;
    assign d_l        = ram_rdata[2*d_width-1 -: d_width];
    assign d_r        = ram_rdata[d_width-1:0];

    function automatic logic signed [d_width-1:0] mix(input logic signed [d_width-1:0] x,
                                                      input logic signed [d_width-1:0] d);
        logic signed [d_width-1:0] e;
        e = d >>> decay_shift;
`ifdef ECHO_SATURATE_EN
        return d_width'(sat_add(64'(x), 64'(e), d_width));
`else
        begin
            logic [d_width:0] s;
            s = {x[d_width-1], x} + {e[d_width-1], e};
            return s[d_width-1:0];
        end
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        ram_we    = 1'b0;
        ram_wdata = '0;
        y_l_d     = y_l_q;
        y_r_d     = y_r_q;
        case (state_q)
            CLEAR: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == PTR_LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (frame_edge) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: state_d = READ;
            READ:    state_d = MIX;
            MIX: begin
                y_l_d   = i_enable ? mix(x_l_q, d_l) : x_l_q;
                y_r_d   = i_enable ? mix(x_r_q, d_r) : x_r_q;
                state_d = WRITE;
            end
            WRITE: begin
                ram_we    = 1'b1;
                ram_wdata = {y_l_q, y_r_q};
                wr_ptr_d  = wr_ptr_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= CLEAR;
            ws_d_q        <= 1'b1;
            dry_pend_q    <= 1'b0;
            wr_ptr_q      <= '0;
            x_l_q         <= '0;
            x_r_q         <= '0;
            y_l_q         <= '0;
            y_r_q         <= '0;
            o_l_data      <= '0;
            o_r_data      <= '0;
            o_sample_tick <= 1'b0;
        end else begin
            state_q       <= state_d;
            ws_d_q        <= i_ws;
            wr_ptr_q      <= wr_ptr_d;
            y_l_q         <= y_l_d;
            y_r_q         <= y_r_d;
            dry_pend_q    <= (state_q == CLEAR) && frame_edge;
            o_sample_tick <= 1'b0;
            if (((state_q == CLEAR) && frame_edge) || (state_q == CAPTURE)) begin
                x_l_q <= i_l_data;
                x_r_q <= i_r_data;
            end
            // Dry frames seen during CLEAR reach the outputs one cycle after capture.
            if (dry_pend_q) begin
                o_l_data      <= x_l_q;
                o_r_data      <= x_r_q;
                o_sample_tick <= 1'b1;
            end else if (state_q == WRITE) begin
                o_l_data      <= y_l_q;
                o_r_data      <= y_r_q;
                o_sample_tick <= 1'b1;
            end
        end
    end

    sample_ram #(
        .WIDTH      (2 * d_width),
        .ADDR_WIDTH (addr_width)
    ) u_ram (
        .clk_i   (mclk),
        .we_i    (ram_we),
        .addr_i  (wr_ptr_q),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_echo_effect.sv
// Bench for echo_effect with an 8-frame delay line and decay_shift 1.
module tb_echo_effect;

    localparam int DW    = 24;
    localparam int DEPTH = 8;

    logic          mclk    = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_ws    = 1'b1;
    logic          i_enable = 1'b1;
    logic [DW-1:0] i_l_data = '0;
    logic [DW-1:0] i_r_data = '0;
    logic [DW-1:0] o_l_data;
    logic [DW-1:0] o_r_data;
    logic          o_sample_tick;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] hist_l[$];
    logic [DW-1:0] hist_r[$];

    typedef struct {
        logic          rst;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          en;
        logic [DW-1:0] el;
        logic [DW-1:0] er;
    } vec_t;

    vec_t tbl[33];

    echo_effect #(
        .d_width     (DW),
        .addr_width  (3),
        .decay_shift (1)
    ) dut (
        .mclk          (mclk),
        .reset_n       (reset_n),
        .i_ws          (i_ws),
        .i_enable      (i_enable),
        .i_l_data      (i_l_data),
        .i_r_data      (i_r_data),
        .o_l_data      (o_l_data),
        .o_r_data      (o_r_data),
        .o_sample_tick (o_sample_tick)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: a delay line of past outputs, y[n] = x[n] + y[n-8]/2 (floor).
    task automatic model_reset();
        hist_l.delete();
        hist_r.delete();
        for (int i = 0; i < DEPTH; i++) begin
            hist_l.push_back('0);
            hist_r.push_back('0);
        end
    endtask

    function automatic logic [DW-1:0] echo_of(input logic [DW-1:0] x, input logic [DW-1:0] d);
        longint s;
        s = longint'($signed(x)) + (longint'($signed(d)) >>> 1);
`ifdef ECHO_SATURATE_EN
        if (s > 64'sd8388607) s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
`endif
        return s[DW-1:0];
    endfunction

    task automatic model_step(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic en,
                              output logic [DW-1:0] ml, output logic [DW-1:0] mr);
        logic [DW-1:0] dl, dr;
        dl = hist_l.pop_front();
        dr = hist_r.pop_front();
        ml = en ? echo_of(l, dl) : l;
        mr = en ? echo_of(r, dr) : r;
        hist_l.push_back(ml);
        hist_r.push_back(mr);
    endtask

    // Called at a negedge; returns at a negedge with the mclk counter released.
    task automatic reset_dut(input int clear_wait);
        @(negedge mclk);
        reset_n = 1'b0;
        i_ws    = 1'b1;
        repeat (2) @(negedge mclk);
        check("reset_l", o_l_data, 0);
        check("reset_r", o_r_data, 0);
        check("reset_tick", o_sample_tick, 0);
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (clear_wait) @(negedge mclk);
        model_reset();
    endtask

    task automatic run_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic en,
                             input int exp_lat,
                             output logic [DW-1:0] ol, output logic [DW-1:0] orr);
        int lat;
        lat      = 0;
        i_l_data = l;
        i_r_data = r;
        i_enable = en;
        i_ws     = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge mclk);
            if (o_sample_tick) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, exp_lat);
        ol  = o_l_data;
        orr = o_r_data;
        @(negedge mclk);
        check("tick_width", o_sample_tick, 0);
        check("hold_l", o_l_data, ol);
        repeat (2) @(negedge mclk);
        i_ws = 1'b1;
        repeat (4) @(negedge mclk);
    endtask

    initial begin
        logic [DW-1:0] ol, orr, ml, mr, rl, rr, sat_l, sat_r;
        logic          en;
        int            ticks;

        for (int i = 0; i < 24; i++) begin
            tbl[i] = '{rst: (i == 0), l: '0, r: '0, en: 1'b1, el: '0, er: '0};
        end
        tbl[0].l   = 24'h100000;  tbl[0].el  = 24'h100000;
        tbl[8].el  = 24'h080000;  tbl[16].el = 24'h040000;
        tbl[3].r   = 24'hF00000;  tbl[3].er  = 24'hF00000;
        tbl[11].er = 24'hF80000;  tbl[19].er = 24'hFC0000;
        for (int i = 24; i < 32; i++) begin
            tbl[i] = '{rst: (i == 24), l: 24'h200000, r: '0, en: 1'b0, el: 24'h200000, er: '0};
        end
        tbl[32] = '{rst: 1'b0, l: '0, r: '0, en: 1'b1, el: 24'h100000, er: '0};

        // No tick during CLEAR without a frame edge.
        reset_dut(0);
        ticks = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge mclk);
            if (o_sample_tick) ticks++;
        end
        check("clear_no_tick", ticks, 0);

        // Frame edges inside CLEAR pass dry after 2 cycles; the last CLEAR cycle is still CLEAR.
        reset_dut(2);
        run_frame(24'h000123, 24'h000321, 1'b1, 2, ol, orr);
        check("clear_dry_l", ol, 24'h000123);
        check("clear_dry_r", orr, 24'h000321);
        reset_dut(DEPTH - 1);
        run_frame(24'h000456, 24'h000654, 1'b1, 2, ol, orr);
        check("clear_last_l", ol, 24'h000456);
        reset_dut(DEPTH);
        model_step(24'h000789, 24'h000987, 1'b1, ml, mr);
        run_frame(24'h000789, 24'h000987, 1'b1, 5, ol, orr);
        check("first_idle_l", ol, ml);
        check("first_idle_r", orr, mr);

        // Impulse / negative impulse / bypass vectors.
        for (int i = 0; i < 33; i++) begin
            if (tbl[i].rst) reset_dut(10);
            run_frame(tbl[i].l, tbl[i].r, tbl[i].en, 5, ol, orr);
            check($sformatf("vec%0d_l", i), ol, tbl[i].el);
            check($sformatf("vec%0d_r", i), orr, tbl[i].er);
        end

        // Full-scale constant input: clamp or wrap at frame 8 onwards.
`ifdef ECHO_SATURATE_EN
        sat_l = 24'h7FFFFF;
        sat_r = 24'h800000;
`else
        sat_l = 24'hBFFFFE;
        sat_r = 24'h400000;
`endif
        reset_dut(10);
        for (int f = 0; f < 16; f++) begin
            run_frame(24'h7FFFFF, 24'h800000, 1'b1, 5, ol, orr);
            check($sformatf("full_l%0d", f), ol, (f < 8) ? 24'h7FFFFF : sat_l);
            check($sformatf("full_r%0d", f), orr, (f < 8) ? 24'h800000 : sat_r);
        end

        // Reset in MIX: outputs drop immediately and the old impulse never echoes.
        reset_dut(10);
        run_frame(24'h100000, 24'h0, 1'b1, 5, ol, orr);
        check("pre_rst_l", ol, 24'h100000);
        i_l_data = '0;
        i_ws     = 1'b0;
        repeat (3) @(negedge mclk);
        reset_n = 1'b0;
        i_ws    = 1'b1;
        #1;
        check("mix_rst_l", o_l_data, 0);
        check("mix_rst_tick", o_sample_tick, 0);
        @(negedge mclk);
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (10) @(negedge mclk);
        model_reset();
        for (int f = 0; f < DEPTH + 1; f++) begin
            model_step('0, '0, 1'b1, ml, mr);
            run_frame('0, '0, 1'b1, 5, ol, orr);
            check($sformatf("post_rst_l%0d", f), ol, ml);
        end

        // Random frames against the delay-line model.
        reset_dut(10);
        for (int f = 0; f < 48; f++) begin
            rl = $urandom_range(0, 1) ? 24'($urandom()) : 24'($urandom_range(0, 4095));
            rr = $urandom_range(0, 1) ? 24'($urandom()) : 24'($urandom_range(0, 4095));
            en = ($urandom_range(0, 3) != 0);
            model_step(rl, rr, en, ml, mr);
            run_frame(rl, rr, en, 5, ol, orr);
            check($sformatf("rand_l%0d", f), ol, ml);
            check($sformatf("rand_r%0d", f), orr, mr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/echo_effect.md
# echo_effect

Feedback echo (delay-line) effect stage placed between the I2S receiver outputs and the effect controller / I2S sender inputs. It captures one stereo frame per word-select period and adds an attenuated copy of its own output from `delay_depth` frames earlier. Both channels are stored in an internal single-port sample RAM. Runs entirely in the master-clock domain.

## Interface
- `d_width`, 24: sample width in bits; two's-complement signed.
- `addr_width`, 12: RAM address width; delay length `delay_depth` = 2^`addr_width` frames.
- `decay_shift`, 1: echo gain = 2^-`decay_shift`; legal range 1..8.

- `mclk`  in  1  master clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_ws`  in  1  word select from the receiver; generated from `mclk`; no synchronizer.
- `i_enable`  in  1  1 = echo applied; 0 = dry bypass.
- `i_l_data`  in  `d_width`  left sample from the receiver.
- `i_r_data`  in  `d_width`  right sample from the receiver.
- `o_l_data`  out  `d_width`  left processed sample; reset 0.
- `o_r_data`  out  `d_width`  right processed sample; reset 0.
- `o_sample_tick`  out  1  one-cycle pulse when outputs update; reset 0.

## Operation
- Frame boundary = falling edge of `i_ws`, detected against a registered copy `ws_d` (reset 1).
- FSM states: CLEAR, IDLE, CAPTURE, READ, MIX, WRITE.
- Reset enters CLEAR. CLEAR writes zero to RAM addresses 0..`delay_depth`-1, one address per cycle, then enters IDLE.
- Frame edges during CLEAR: inputs are registered straight to the outputs (dry), `o_sample_tick` pulses, and no RAM access occurs.
- IDLE → CAPTURE on a frame edge. CAPTURE latches `i_l_data`/`i_r_data` into x_l/x_r.
- READ drives RAM address `wr_ptr`. The RAM word is {l,r}, 2·`d_width` bits wide.
- MIX: d = RAM data, i.e. the output written `delay_depth` frames earlier.
  - y = x + (d >>> `decay_shift`), arithmetic shift per channel.
  - Sum formed at `d_width`+1 bits, then reduced per Configuration.
  - If `i_enable`=0 (sampled in MIX): y = x.
- WRITE: writes {y_l,y_r} to `wr_ptr`, registers y onto the outputs, pulses `o_sample_tick`, increments `wr_ptr` modulo `delay_depth`, then returns to IDLE.
- The bypass frame writes y = x, so an echo of the dry signal follows re-enable.
- Frame edges while in CAPTURE..WRITE are ignored. This cannot happen at the nominal rate of 256 `mclk` per frame.
- Outputs hold their value between ticks.

## Timing
- Edge detected in cycle 0 (`i_ws`=0, `ws_d`=1).
- CAPTURE = cycle 1, READ = cycle 2, RAM data valid = cycle 3 (MIX).
- WRITE = cycle 4: outputs and `o_sample_tick` valid in cycle 5 (registered). Latency from the edge to output: 5 `mclk`.
- CLEAR duration: exactly `delay_depth` cycles after reset release.
- CLEAR-mode dry output is valid 2 cycles after the edge.
- `reset_n` low at any time: asynchronously zeroes outputs, tick, `wr_ptr`, `ws_d`=1 and FSM=CLEAR. RAM contents are undefined until CLEAR completes.

## Configuration
- `ECHO_SATURATE_EN` defined: the (`d_width`+1)-bit sum is clamped to [-2^(`d_width`-1), 2^(`d_width`-1)-1].
- Not defined: the sum is truncated to `d_width` bits (two's-complement wrap).

## Structure
- Shared package `audio_pkg`:
  - FSM state enum `echo_state_t`.
  - Default constants D_WIDTH=24 and ECHO_ADDR_WIDTH=12.
  - A `sat_add` function used when `ECHO_SATURATE_EN` is defined.
- One sub-module: `sample_ram`, a single-port synchronous RAM (one-cycle read latency, write-first not required) parameterised by width and address width. It must infer block RAM.

## Test plan
- Reset, `addr_width`=3: outputs 0, tick 0, and no tick during the 8 CLEAR cycles without a frame edge. A frame edge during CLEAR with L=0x000123 → `o_l_data`=0x000123 2 cycles later.
- Impulse, `addr_width`=3, `decay_shift`=1, L=0x100000 in frame 0, then zeros → `o_l_data` = 0x100000 (frame 0), 0x080000 (frame 8), 0x040000 (frame 16), 0 elsewhere; right channel stays 0.
- Negative impulse R=-0x100000 → `o_r_data` = -0x100000, then -0x080000 at frame 8. Also confirms `wr_ptr` wrap 7→0.
- Constant L=0x7FFFFF for 16 frames:
  - with `ECHO_SATURATE_EN`, output from frame 8 on is 0x7FFFFF;
  - without it, frame 8 output wraps to 0xBFFFFE (negative).
- `i_enable`=0 with L=0x200000 → output equals input every frame. Re-enable at frame 8 with zero input → output 0x100000.
- `reset_n` pulsed low during MIX → outputs 0 immediately, CLEAR re-runs, and the echo of the pre-reset impulse never appears.
